// File: rtl/fb_pkg.sv
// Package for the frame ping-pong buffer.
// Holds the controller state enum, default geometry constants and a helper
// that sizes the RAM address from the frame depth.
package fb_pkg;

   localparam int unsigned FB_DATA_W = 16;
   localparam int unsigned FB_ADDR_W = 16;
   localparam int unsigned FB_DEPTH  = 22500;  // 150 x 150 pixels

   // IDLE: no complete frame; SHOW: displaying while the writer fills;
   // PEND: writer finished, waiting for the display frame start.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      PEND = 2'd2
   } fb_state_t;

   // Bits needed to index one bank; never less than one.
   function automatic int unsigned fb_addr_bits(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// One frame bank: single-clock RAM, one write port, one read port, read data
// registered (one cycle latency). Contents are never reset.
// Ports:
//   i_clk             clock
//   i_we/i_waddr/i_wdata  write strobe, address, data
//   i_re/i_raddr      read strobe and address
//   o_rdata           read data, updated the cycle after i_re
module fb_bank_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 22500,
   parameter int unsigned AW     = 15
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_pingpong_buffer.sv
// Double-buffered frame store between a capture (write) side and a display
// (read) side on one clock. The writer fills wr_bank while the display reads
// rd_bank (always the other bank). A finished frame is handed over at the next
// display frame start, or immediately when nothing is being shown.
// Optional feature: define FB_DROP_CNT_EN to add the drop_cnt output, a
// saturating count of dropped writes that clears on every bank swap.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   w_en/w_addr/w_data/w_frame_done    capture side write and end-of-frame pulse
//   r_en/r_addr/r_frame_start          display side read and vsync pulse
//   r_data/r_valid                     read result, one cycle after r_en
//   w_err                              a write was dropped last cycle
//   frame_ready                        a completed frame is on display
//   wr_bank/rd_bank                    current bank indices
//   drop_cnt                           (FB_DROP_CNT_EN only) dropped writes
module frame_pingpong_buffer
   import fb_pkg::*;
#(
   parameter int unsigned DATA_W = FB_DATA_W,
   parameter int unsigned ADDR_W = FB_ADDR_W,
   parameter int unsigned DEPTH  = FB_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              w_frame_done,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic              r_frame_start,
   output logic [DATA_W-1:0] r_data,
   output logic              r_valid,
   output logic              w_err,
   output logic              frame_ready,
   output logic              wr_bank,
   output logic              rd_bank
`ifdef FB_DROP_CNT_EN
   ,
   output logic [15:0]       drop_cnt
`endif
);

   localparam int unsigned     RAM_AW  = fb_addr_bits(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   fb_state_t         r_state;
   fb_state_t         w_state_d;
   logic              r_wr_bank;
   logic              w_swap;
   logic              w_wr_ok;
   logic              w_rd_ok;
   logic              w_drop;
   logic              r_rd_hit;
   logic              r_rd_sel;
   logic [DATA_W-1:0] w_q0;
   logic [DATA_W-1:0] w_q1;

   always_comb begin
      w_state_d = r_state;
      w_swap    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_frame_done) begin
               w_swap    = 1'b1;
               w_state_d = SHOW;
            end
         end
         SHOW: begin
            if (w_frame_done) begin
               // Display already at a frame boundary: hand over right away.
               if (r_frame_start) w_swap = 1'b1;
               else               w_state_d = PEND;
            end
         end
         PEND: begin
            if (r_frame_start) begin
               w_swap    = 1'b1;
               w_state_d = SHOW;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   // The write bank is frozen in PEND, so writes there would corrupt the
   // finished frame.
   assign w_wr_ok = w_en && (r_state != PEND) && ({1'b0, w_addr} < DEPTH_L);
   assign w_drop  = w_en && !w_wr_ok;
   assign w_rd_ok = r_en && (r_state != IDLE) && ({1'b0, r_addr} < DEPTH_L);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_wr_bank <= 1'b0;
         r_valid   <= 1'b0;
         w_err     <= 1'b0;
         r_rd_hit  <= 1'b0;
         r_rd_sel  <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         if (w_swap) r_wr_bank <= ~r_wr_bank;
         r_valid  <= r_en;
         w_err    <= w_drop;
         r_rd_hit <= w_rd_ok;
         r_rd_sel <= ~r_wr_bank;  // bank read this cycle, before any swap
      end
   end

   fb_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (RAM_AW)
   ) u_bank0 (
      .i_clk   (clk),
      .i_we    (w_wr_ok && !r_wr_bank),
      .i_waddr (w_addr[RAM_AW-1:0]),
      .i_wdata (w_data),
      .i_re    (w_rd_ok && r_wr_bank),
      .i_raddr (r_addr[RAM_AW-1:0]),
      .o_rdata (w_q0)
   );

   fb_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (RAM_AW)
   ) u_bank1 (
      .i_clk   (clk),
      .i_we    (w_wr_ok && r_wr_bank),
      .i_waddr (w_addr[RAM_AW-1:0]),
      .i_wdata (w_data),
      .i_re    (w_rd_ok && !r_wr_bank),
      .i_raddr (r_addr[RAM_AW-1:0]),
      .o_rdata (w_q1)
   );

   // Misses (IDLE, out of range, no read) return zero; r_rd_hit resets low so
   // r_data clears asynchronously with the rest of the outputs.
   always_comb begin
      r_data = '0;
      if (r_rd_hit) r_data = r_rd_sel ? w_q1 : w_q0;
   end

   assign frame_ready = (r_state != IDLE);
   assign wr_bank     = r_wr_bank;
   assign rd_bank     = ~r_wr_bank;

`ifdef FB_DROP_CNT_EN
   logic [15:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   r_drop_cnt <= 16'd0;
      else if (w_swap)                              r_drop_cnt <= 16'd0;
      else if (w_drop && (r_drop_cnt != 16'hFFFF))  r_drop_cnt <= r_drop_cnt + 16'd1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: doc/frame_pingpong_buffer.md
FRAME_PINGPONG_BUFFER -- requirements
Module: frame_pingpong_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: pixel width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16: pixel address width.
REQ-003 The block SHALL have parameter DEPTH, default 22500 (150x150): pixels per frame, at most 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1: the only clock.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port w_en, input, 1: write strobe from the capture side.
REQ-007 The block SHALL have port w_addr, input, ADDR_W: write pixel address.
REQ-008 The block SHALL have port w_data, input, DATA_W: write pixel.
REQ-009 The block SHALL have port w_frame_done, input, 1: one-cycle pulse marking the last pixel of a written frame.
REQ-010 The block SHALL have port r_en, input, 1: read strobe from the display side.
REQ-011 The block SHALL have port r_addr, input, ADDR_W: read pixel address.
REQ-012 The block SHALL have port r_frame_start, input, 1: one-cycle pulse at display frame start (vsync).
REQ-013 The block SHALL have port r_data, output, DATA_W: read pixel.
REQ-014 The block SHALL have port r_valid, output, 1: r_data qualifier.
REQ-015 The block SHALL have port w_err, output, 1: registered flag for a dropped write.
REQ-016 The block SHALL have port frame_ready, output, 1: high while a completed frame is on display.
REQ-017 The block SHALL have port wr_bank and rd_bank, output, 1 each: current bank indices.

Function
REQ-018 Storage SHALL be two banks of DEPTH x DATA_W; writes go to wr_bank and reads come from rd_bank, with rd_bank always equal to !wr_bank.
REQ-019 The state machine SHALL have the states IDLE (no complete frame), SHOW (displaying; writer filling) and PEND (writer finished; awaiting r_frame_start).
REQ-020 IDLE + w_frame_done SHALL swap the banks in the same edge and go to SHOW.
REQ-021 SHOW + w_frame_done without r_frame_start SHALL go to PEND.
REQ-022 SHOW + w_frame_done together with r_frame_start SHALL swap immediately and stay in SHOW.
REQ-023 PEND + r_frame_start SHALL swap and go to SHOW.
REQ-024 PEND + w_frame_done SHALL be ignored.
REQ-025 A write SHALL be accepted only if w_en=1, the state is not PEND, and w_addr<DEPTH; otherwise it is dropped and w_err=1 on the next cycle, and w_err=0 on a cycle with no w_en.
REQ-026 Read latency SHALL be 1 cycle: r_valid is r_en delayed by one cycle.
REQ-027 r_data SHALL be 0 when the read occurred in IDLE or with r_addr>=DEPTH.
REQ-028 A bank swap SHALL take effect for reads issued the cycle after the swap edge; a read issued on the swap edge returns old-bank data.
REQ-029 Writes SHALL be accepted in the w_frame_done cycle itself (last pixel).
REQ-030 frame_ready SHALL be 1 in SHOW and PEND, and 0 in IDLE.

Reset
REQ-031 rst_n low SHALL force state=IDLE, wr_bank=0, rd_bank=1, r_data=0, r_valid=0, w_err=0, frame_ready=0 and drop_cnt=0, asynchronously.
REQ-032 Memory contents SHALL NOT be reset; a frame in progress is discarded and the first w_frame_done after reset behaves as in IDLE.

Configuration
REQ-033 With FB_DROP_CNT_EN defined, the block SHALL add output drop_cnt[15:0], which counts dropped writes, saturates at 16'hFFFF, and clears on each bank swap.
REQ-034 Without FB_DROP_CNT_EN, the block SHALL have no drop_cnt port and no counter logic.

Structure
REQ-035 Package fb_pkg SHALL hold the state enum fb_state_t (IDLE, SHOW, PEND) and the default DATA_W/ADDR_W/DEPTH constants.
REQ-036 The block SHALL use one sub-module, fb_bank_ram (single-clock 1W1R synchronous RAM, registered read), instantiated twice.

Verification
REQ-037 Reset, write 0..22499 with data=addr, pulse w_frame_done -> next cycle state SHOW, rd_bank=0, frame_ready=1; reading addr 100 gives r_data=100 with r_valid one cycle later.
REQ-038 In SHOW, write a frame of data=16'hAAAA plus w_frame_done, with no r_frame_start -> PEND; reads still return old data; a w_en in PEND gives w_err=1; r_frame_start -> swap, reads return 16'hAAAA.
REQ-039 In SHOW, assert w_frame_done and r_frame_start in the same cycle -> immediate swap, state stays SHOW.
REQ-040 Write w_addr=22500 -> dropped, w_err=1; read r_addr=22500 -> r_data=0, r_valid=1.
REQ-041 Drop rst_n low mid-frame at pixel 5000 -> outputs zero immediately, state IDLE, frame_ready=0; reads return 0 until the next w_frame_done.
REQ-042 With FB_DROP_CNT_EN defined, 3 writes in PEND -> drop_cnt=3; after r_frame_start -> drop_cnt=0.
